// File: rtl/mdl_alignp_receive.sv
// Serial ALIGNp receiver model: deserialises a differential bit stream, hunts for
// the ALIGNp word, tracks word lock and counts boundary errors once locked.
module mdl_alignp_receive #(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_p,
    input  logic        rx_n,
    input  logic [39:0] align_p,
    output logic [39:0] rx_word,
    output logic        align_det,
    output logic        word_valid,
    output logic        locked,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {IDLE, HUNT, SYNC, LOCKED} state_t;

    localparam logic [3:0] LOCK_C   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_COUNT);

    state_t      state_q, state_d;
    logic [39:0] word_q, word_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  match_q, match_d;
    logic [3:0]  miss_q, miss_d;
    logic [15:0] err_q, err_d;
    logic        locked_q, locked_d;
    logic        align_det_q, align_det_d;
    logic        word_valid_q, word_valid_d;

    logic        bit_ok;
    logic [39:0] shift_w;
    logic        hit;
    logic        bnd;

    // Equal legs or X/Z on either leg evaluate as not-valid and fall to the idle path.
    assign bit_ok  = rx_p ^ rx_n;
    assign shift_w = {word_q[38:0], rx_p};
    assign hit     = (shift_w == align_p);
    assign bnd     = (bit_cnt_q == 6'd39);

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        bit_cnt_d    = bit_cnt_q;
        match_d      = match_q;
        miss_d       = miss_q;
        err_d        = err_q;
        locked_d     = locked_q;
        align_det_d  = 1'b0;
        word_valid_d = 1'b0;
        if (bit_ok) begin
            word_d = shift_w;
            unique case (state_q)
                IDLE, HUNT: begin
                    state_d = HUNT;
                    if (hit) begin
                        align_det_d = 1'b1;
                        bit_cnt_d   = 6'd0;
                        match_d     = 4'd1;
                        if (LOCK_C == 4'd1) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            miss_d   = 4'd0;
                        end else begin
                            state_d = SYNC;
                        end
                    end
                end
                SYNC: begin
                    bit_cnt_d = bnd ? 6'd0 : bit_cnt_q + 6'd1;
                    if (bnd) begin
                        word_valid_d = 1'b1;
                        if (hit) begin
                            align_det_d = 1'b1;
                            match_d     = match_q + 4'd1;
                            if (match_q + 4'd1 >= LOCK_C) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                                miss_d   = 4'd0;
                            end
                        end else begin
                            state_d = HUNT;
                            match_d = 4'd0;
                        end
                    end
                end
                LOCKED: begin
                    bit_cnt_d = bnd ? 6'd0 : bit_cnt_q + 6'd1;
                    if (bnd) begin
                        word_valid_d = 1'b1;
                        if (hit) begin
                            align_det_d = 1'b1;
                            miss_d      = 4'd0;
                        end else begin
                            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                            miss_d = miss_q + 4'd1;
                            if (miss_q + 4'd1 >= UNLOCK_C) begin
                                state_d  = HUNT;
                                locked_d = 1'b0;
                                match_d  = 4'd0;
                                miss_d   = 4'd0;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            // Idle bit: drop everything except the captured word and the error history.
            state_d   = IDLE;
            locked_d  = 1'b0;
            bit_cnt_d = 6'd0;
            match_d   = 4'd0;
            miss_d    = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            word_q       <= 40'd0;
            bit_cnt_q    <= 6'd0;
            match_q      <= 4'd0;
            miss_q       <= 4'd0;
            err_q        <= 16'd0;
            locked_q     <= 1'b0;
            align_det_q  <= 1'b0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            bit_cnt_q    <= bit_cnt_d;
            match_q      <= match_d;
            miss_q       <= miss_d;
            err_q        <= err_d;
            locked_q     <= locked_d;
            align_det_q  <= align_det_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign rx_word    = word_q;
    assign align_det  = align_det_q;
    assign word_valid = word_valid_q;
    assign locked     = locked_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_mdl_alignp_receive.sv
// Scoreboard bench for mdl_alignp_receive: expected output values are queued against
// the sampling edge of each word's last bit and checked on the following falling edge.
module tb_mdl_alignp_receive;

    localparam logic [39:0] ALIGN = 40'hF3_5A6C_91D2;
    localparam logic [39:0] BAD   = ALIGN ^ (40'd1 << 20);

    localparam int S_ADET = 0;
    localparam int S_WVLD = 1;
    localparam int S_LOCK = 2;
    localparam int S_ERR  = 3;
    localparam int S_WORD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_p, rx_n;
    logic [39:0] align_p;
    logic [39:0] rx_word;
    logic        align_det, word_valid, locked;
    logic [15:0] err_count;

    int checks   = 0;
    int failures = 0;
    int pe       = 0;

    typedef struct {
        int          at;
        int          sel;
        logic [39:0] val;
        string       tag;
    } exp_t;
    exp_t sb[$];

    mdl_alignp_receive #(.LOCK_COUNT(4), .UNLOCK_COUNT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_p      (rx_p),
        .rx_n      (rx_n),
        .align_p   (align_p),
        .rx_word   (rx_word),
        .align_det (align_det),
        .word_valid(word_valid),
        .locked    (locked),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pe <= pe + 1;

    task automatic chk(input string tag, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", tag, act, exp, pe);
        end
    endtask

    function automatic logic [39:0] sig(input int s);
        case (s)
            S_ADET:  return {39'd0, align_det};
            S_WVLD:  return {39'd0, word_valid};
            S_LOCK:  return {39'd0, locked};
            S_ERR:   return {24'd0, err_count};
            default: return rx_word;
        endcase
    endfunction

    task automatic push(input int at, input int sel, input logic [39:0] v, input string tag);
        exp_t x;
        x.at = at; x.sel = sel; x.val = v; x.tag = tag;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == pe) begin
                chk(sb[i].tag, sig(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    end

    // Returns the edge count at which the driven bit is sampled.
    task automatic send_bit(input logic v, input logic b, output int e);
        @(posedge clk);
        #1;
        rx_p = b;
        rx_n = v ? ~b : b;
        e = pe + 1;
    endtask

    task automatic send_word(input logic [39:0] w, output int e);
        for (int i = 39; i >= 0; i--) send_bit(1'b1, w[i], e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, e1, e12, e16, f1, f2, f4, f5, i1, g1, g2, g4;
        reset   = 1'b1;
        rx_p    = 1'b0;
        rx_n    = 1'b0;
        align_p = ALIGN;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_word", rx_word, 40'd0);
        chk("rst_adet", {39'd0, align_det}, 40'd0);
        chk("rst_wvld", {39'd0, word_valid}, 40'd0);
        chk("rst_lock", {39'd0, locked}, 40'd0);
        chk("rst_err", {24'd0, err_count}, 40'd0);
        reset = 1'b0;

        // Bring-up: lock after four aligned words, 120 edges after first align_det.
        send_word(ALIGN, e1);
        push(e1, S_ADET, 40'd1, "first_adet");
        push(e1, S_WVLD, 40'd0, "hunt_no_wvld");
        push(e1 + 1, S_ADET, 40'd0, "adet_one_cycle");
        send_word(ALIGN, e);
        push(e, S_WVLD, 40'd1, "sync_wvld");
        send_word(ALIGN, e);
        push(e, S_LOCK, 40'd0, "not_yet_locked");
        send_word(ALIGN, e);
        push(e1 + 120, S_LOCK, 40'd1, "lock_at_120");
        push(e1 + 120, S_ERR, 40'd0, "lock_err0");
        push(e1 + 120, S_WORD, ALIGN, "lock_word");
        send_word(ALIGN, e);
        send_word(ALIGN, e);
        push(e, S_ADET, 40'd1, "locked_adet");

        // Single bad word, then a good one, then another single bad word.
        send_word(BAD, e);
        push(e, S_ADET, 40'd0, "bad1_no_adet");
        push(e, S_ERR, 40'd1, "bad1_err");
        push(e, S_LOCK, 40'd1, "bad1_still_lock");
        send_word(ALIGN, e);
        push(e, S_ADET, 40'd1, "recover_adet");
        send_word(BAD, e);
        push(e, S_LOCK, 40'd1, "miss_reset_lock");
        push(e, S_ERR, 40'd2, "bad2_err");
        send_word(ALIGN, e);

        // Two consecutive bad words drop lock; re-lock 160 bits later.
        send_word(BAD, e);
        push(e, S_LOCK, 40'd1, "dbl_first_lock");
        send_word(BAD, e12);
        push(e12, S_LOCK, 40'd0, "dbl_unlock");
        push(e12, S_ERR, 40'd4, "dbl_err");
        send_word(ALIGN, e);
        push(e, S_ADET, 40'd1, "rehunt_adet");
        send_word(ALIGN, e);
        send_word(ALIGN, e);
        push(e, S_LOCK, 40'd0, "relock_not_yet");
        send_word(ALIGN, e16);
        push(e12 + 160, S_LOCK, 40'd1, "relock_160");

        // Bit slip: one extra bit shifts the phase.
        send_bit(1'b1, 1'b0, e);
        push(e16 + 40, S_ADET, 40'd0, "slip_no_adet");
        push(e16 + 40, S_ERR, 40'd5, "slip_err");
        push(e16 + 40, S_LOCK, 40'd1, "slip_lock_hold");
        push(e16 + 80, S_LOCK, 40'd0, "slip_unlock");
        push(e16 + 80, S_ERR, 40'd6, "slip_err2");
        send_word(ALIGN, f1);
        send_word(ALIGN, f2);
        push(f2, S_ADET, 40'd1, "slip_new_phase");
        send_word(ALIGN, e);
        send_word(ALIGN, f4);
        push(f4, S_LOCK, 40'd0, "slip_relock_wait");
        send_word(ALIGN, f5);
        push(f5, S_LOCK, 40'd1, "slip_relock");
        push(f5, S_WVLD, 40'd1, "slip_relock_wvld");

        // Burst gap: idle bits drop lock at once, word and errors hold.
        send_bit(1'b0, 1'b0, i1);
        push(i1, S_LOCK, 40'd0, "idle_unlock");
        push(i1, S_ERR, 40'd6, "idle_err_hold");
        push(i1, S_WORD, ALIGN, "idle_word_hold");
        send_bit(1'b0, 1'b1, e);
        send_bit(1'b0, 1'b0, e);
        push(e, S_WVLD, 40'd0, "idle_no_wvld");
        send_word(ALIGN, g1);
        push(g1, S_ADET, 40'd1, "resume_adet");
        push(g1, S_WVLD, 40'd0, "resume_hunt_wvld");
        send_word(ALIGN, g2);
        push(g2, S_WVLD, 40'd1, "resume_wvld");
        send_word(ALIGN, e);
        send_word(ALIGN, g4);
        push(g4, S_LOCK, 40'd1, "resume_lock");

        // Asynchronous reset mid-word while locked.
        send_word(ALIGN, e);
        for (int i = 39; i >= 30; i--) send_bit(1'b1, ALIGN[i], e);
        #2;
        chk("pre_rst_err", {24'd0, err_count}, 40'd6);
        chk("pre_rst_lock", {39'd0, locked}, 40'd1);
        rx_p  = 1'b0;
        rx_n  = 1'b0;
        reset = 1'b1;
        #1;
        chk("arst_lock", {39'd0, locked}, 40'd0);
        chk("arst_err", {24'd0, err_count}, 40'd0);
        chk("arst_word", rx_word, 40'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_word(ALIGN, e1);
        push(e1, S_ADET, 40'd1, "post_rst_adet");
        send_word(ALIGN, e);
        send_word(ALIGN, e);
        send_word(ALIGN, e);
        push(e, S_LOCK, 40'd1, "post_rst_lock");
        push(e, S_ERR, 40'd0, "post_rst_err");

        repeat (3) @(posedge clk);
        #1;
        chk("sb_left", 40'(sb.size()), 40'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdl_alignp_receive.md
# mdl_alignp_receive

Bench receiver model that sits directly downstream of the ALIGNp serial transmit model. It samples the differential serial stream one bit per clock, shifts it into a 40-bit word, and hunts for the ALIGNp pattern. Once it sees enough consecutive aligned patterns it declares word lock, then monitors every 40-bit boundary and reports errors and loss of lock. Testbenches use it to check link bring-up, bit slips and burst gaps.

## Interface
- LOCK_COUNT, 4: consecutive aligned ALIGNp words required to assert lock (1..15)
- UNLOCK_COUNT, 2: consecutive mismatching boundary words that drop lock (1..15)
- clk  input  1  bit clock; one serial bit sampled per rising edge
- reset  input  1  reset, asynchronous, active-high; clock clk
- rx_p  input  1  serial data, positive leg; first bit of a word is the word's MSB
- rx_n  input  1  serial data, negative leg
- align_p  input  40  expected ALIGNp pattern, static during operation
- rx_word  output  40  last 40 received bits; bit 0 is the newest
- align_det  output  1  one-cycle pulse: a word matching align_p completed this edge
- word_valid  output  1  one-cycle pulse at each 40-bit boundary while in SYNC or LOCKED
- locked  output  1  word lock held
- err_count  output  16  boundary mismatches while LOCKED; saturates at 16'hFFFF

## Operation
- Bit validity: a bit is valid only when (rx_p ^ rx_n) == 1. Equal legs or X/Z count as idle. The data bit is rx_p.
- On a valid bit: rx_word <= {rx_word[38:0], rx_p}. Comparison uses this new value (the "next word").
- States:
  - IDLE: entered on reset or on any idle bit from any state.
  - HUNT: compare the next word on every valid bit.
  - SYNC: compare only at 40-bit boundaries.
  - LOCKED: compare only at 40-bit boundaries.
- IDLE, on a valid bit: go to HUNT and perform the HUNT comparison on that same bit.
- HUNT:
  - Next word == align_p: go to SYNC, bit_cnt=0, match_cnt=1, pulse align_det.
  - If LOCK_COUNT==1, go straight to LOCKED instead.
- SYNC/LOCKED: bit_cnt increments on every valid bit. A boundary is a valid bit when bit_cnt==39; bit_cnt then wraps to 0. word_valid pulses at each boundary.
- SYNC boundary:
  - Match: pulse align_det, match_cnt++. Reaching LOCK_COUNT: go to LOCKED, locked=1, miss_cnt=0.
  - Mismatch: go to HUNT, match_cnt=0.
- LOCKED boundary:
  - Match: pulse align_det, miss_cnt=0.
  - Mismatch: err_count++ (saturating), miss_cnt++. Reaching UNLOCK_COUNT: go to HUNT, locked=0.
- Idle bit from any state:
  - Go to IDLE; clear locked, bit_cnt, match_cnt and miss_cnt.
  - rx_word and err_count hold.
- err_count clears only on reset.

## Timing
- Reset values: rx_word=0, align_det=0, word_valid=0, locked=0, err_count=0, state IDLE. Reset mid-lock takes effect immediately (asynchronous).
- All outputs are registered and update on the sampling edge.
- align_det and word_valid are high for exactly one cycle after the edge that captured the word's last bit.
- Lock latency: locked rises on the edge capturing the last bit of the LOCK_COUNT-th consecutive matching word. With the default, that is 3×40 = 120 edges after the first align_det.
- Unlock latency: locked falls on the boundary edge of the UNLOCK_COUNT-th consecutive bad word.
- An idle bit drops locked on the same edge that samples it.
- A HUNT match at edge E places the next boundary at edge E+40. A new match always resets boundary phase, so a re-lock after a bit slip follows the new phase.

## Test plan
- Continuous ALIGNp from the transmit model, burst_en high after reset:
  - First align_det within 40 edges.
  - align_det every 40 cycles thereafter.
  - locked=1 exactly 120 edges after the first align_det.
  - err_count=0.
- Locked; invert one bit inside one word:
  - At that boundary: err_count=1, no align_det, locked stays 1.
  - Next word matches, miss_cnt resets.
- Locked; corrupt two consecutive words:
  - locked falls on the second bad boundary, err_count=2.
  - Re-lock 160 bits after clean data resumes.
- Locked; insert one extra bit (bit slip):
  - Next boundary mismatches.
  - Lock is lost after UNLOCK_COUNT boundaries, then HUNT finds the new phase and locked returns.
- burst_en low (X on rx):
  - locked=0 on the first idle sample, word_valid stops.
  - Resuming the burst re-locks in ≤200 bits.
- Assert reset while locked:
  - All outputs go to 0 asynchronously, including err_count.
  - Normal lock is reached after release.
